gaussian_window: RTL and testbench

Streaming 7x7 window generator sitting directly upstream of `gaussian_core`. Accepts a raster-order 8-bit pixel stream, buffers the six previous image rows in on-chip line buffers, and presents a fully populated 7x7 neighbourhood as a packed 392-bit word whenever one is complete. Only interior windows are produced; no border padding. The output word drops straight onto `gaussian_core.input_pixels`.

---
 rtl/gaussian_window.sv | 145 ++++++++++++++
 tb/tb_gaussian_window.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window.sv
// rtl/gaussian_window.sv - streaming 7x7 window generator with six line buffers
module gaussian_window #(
    parameter int BITS  = 8,
    parameter int WIDTH = 7,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BITS-1:0]               pixel_in,
    input  logic                          pixel_valid,
    input  logic                          sof,
    output logic [WIDTH*WIDTH*BITS-1:0]   window_out,
    output logic                          window_valid,
    output logic [$clog2(IMG_H)-1:0]      center_row,
    output logic [$clog2(IMG_W)-1:0]      center_col,
    output logic                          frame_done
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int NLB = WIDTH - 1;
    localparam int WB  = WIDTH * WIDTH * BITS;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FULL = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_FULL = RW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_HALF = CW'(WIDTH / 2);
    localparam logic [RW-1:0] ROW_HALF = RW'(WIDTH / 2);

    logic [CW-1:0]   col_q, col_d, cur_col;
    logic [RW-1:0]   row_q, row_d, cur_row;
    logic            complete;
    logic            last_pixel;

    // Line buffers are never reset: rows 0..5 of a frame refill them first.
    logic [BITS-1:0] lb_q    [NLB][IMG_W];
    logic [BITS-1:0] win_q   [WIDTH][WIDTH];
    logic [BITS-1:0] new_col [WIDTH];

    logic            valid_q;
    logic            done_q;
    logic [RW-1:0]   crow_q;
    logic [CW-1:0]   ccol_q;

    // Position of the pixel being accepted (sof forces it to the origin) and the next position.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (pixel_valid && sof) begin
            cur_col = '0;
            cur_row = '0;
        end
        col_d = col_q;
        row_d = row_q;
        if (pixel_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
        complete   = pixel_valid && (cur_row >= ROW_FULL) && (cur_col >= COL_FULL);
        last_pixel = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    // New window column: oldest row (six back) at the top, incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < WIDTH; r++) begin
            new_col[r] = (r == WIDTH - 1) ? pixel_in : lb_q[NLB-1-r][cur_col];
        end
    end

    // Raster position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Line-buffer column shift: each buffer takes the one above it, LB0 takes the new pixel.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb_q[0][cur_col] <= pixel_in;
            for (int k = 1; k < NLB; k++) begin
                lb_q[k][cur_col] <= lb_q[k-1][cur_col];
            end
        end
    end

    // Window shift register: shift left on every accepted pixel, new column enters on the right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < WIDTH; r++) begin
                for (int c = 0; c < WIDTH; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (pixel_valid) begin
            for (int r = 0; r < WIDTH; r++) begin
                for (int c = 0; c < WIDTH - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][WIDTH-1] <= new_col[r];
            end
        end
    end

    // Registered status: valid/done pulse per completed window; centre holds between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            crow_q  <= '0;
            ccol_q  <= '0;
        end else begin
            valid_q <= complete;
            done_q  <= complete && last_pixel;
            if (complete) begin
                crow_q <= cur_row - ROW_HALF;
                ccol_q <= cur_col - COL_HALF;
            end
        end
    end

    // Pack A[r][c] with A[0][0] in the most significant byte.
    for (genvar gr = 0; gr < WIDTH; gr++) begin : g_row
        for (genvar gc = 0; gc < WIDTH; gc++) begin : g_col
            assign window_out[WB-1-BITS*(WIDTH*gr+gc) -: BITS] = win_q[gr][gc];
        end
    end

    assign window_valid = valid_q;
    assign frame_done   = done_q;
    assign center_row   = crow_q;
    assign center_col   = ccol_q;

endmodule

// File: tb/tb_gaussian_window.sv
// tb/tb_gaussian_window.sv - scoreboard bench for gaussian_window on a 16x16 image
module tb_gaussian_window;

    localparam int W = 16;
    localparam int H = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   pixel_in;
    logic         pixel_valid;
    logic         sof;
    logic [391:0] window_out;
    logic         window_valid;
    logic [3:0]   center_row;
    logic [3:0]   center_col;
    logic         frame_done;

    always #5 clk = ~clk;

    gaussian_window #(.BITS(8), .WIDTH(7), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
        .window_out(window_out), .window_valid(window_valid),
        .center_row(center_row), .center_col(center_col), .frame_done(frame_done)
    );

    typedef struct {
        logic [391:0] w;
        int           r;
        int           c;
        bit           fd;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           errors = 0;
    int           nwin = 0;
    int           nfd = 0;
    logic [7:0]   img [H][W];
    int           mr = 0;
    int           mc = 0;
    bit           capture_first = 0;
    logic [391:0] first_w = '0;

    function automatic logic [391:0] build(input int r, input int c);
        logic [391:0] w;
        w = '0;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                w[391-8*(7*i+j) -: 8] = img[r-6+i][c-6+j];
        return w;
    endfunction

    // Reference: remember the frame as an image; any pixel at row>=6,col>=6 closes a window.
    task automatic model_accept(input logic [7:0] p, input bit s);
        exp_t e;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        if (mr >= 6 && mc >= 6) begin
            e.w  = build(mr, mc);
            e.r  = mr - 3;
            e.c  = mc - 3;
            e.fd = (mr == H - 1) && (mc == W - 1);
            q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic send(input logic [7:0] p, input bit s, input int gap);
        @(negedge clk);
        while ($urandom_range(0, 99) < gap) begin
            pixel_valid = 1'b0;
            sof         = 1'($urandom_range(0, 1));
            pixel_in    = 8'($urandom);
            @(negedge clk);
        end
        pixel_valid = 1'b1;
        sof         = s;
        pixel_in    = p;
        model_accept(p, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            sof         = 1'b0;
        end
    endtask

    // kind 0: 16r+c, 1: inverted, 2: constant 200, 3: random. Stops before (stop_r, stop_c).
    task automatic send_frame(input int kind, input int gap, input bit use_sof,
                              input int stop_r, input int stop_c);
        logic [7:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                case (kind)
                    0:       p = 8'(16 * r + c);
                    1:       p = ~8'(16 * r + c);
                    2:       p = 8'd200;
                    default: p = 8'($urandom);
                endcase
                send(p, use_sof && r == 0 && c == 0, gap);
            end
        end
    endtask

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: sample one time unit after each rising edge and compare against the scoreboard.
    logic [391:0] prev_w = '0;
    logic [3:0]   prev_r = '0;
    logic [3:0]   prev_c = '0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            checks++;
            if (window_out !== '0 || window_valid !== 1'b0 || frame_done !== 1'b0 ||
                center_row !== '0 || center_col !== '0) begin
                errors++;
                $display("FAIL reset_outputs: valid=%b done=%b row=%0d col=%0d nonzero_window=%b",
                         window_valid, frame_done, center_row, center_col, window_out != '0);
            end
        end else if (window_valid === 1'b1) begin
            checks++;
            if (pixel_valid !== 1'b1) begin
                errors++;
                $display("FAIL valid_in_gap: window_valid=1 with pixel_valid=%b", pixel_valid);
            end
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: window_valid=1 with empty scoreboard");
            end else begin
                e = q.pop_front();
                checks++;
                if (window_out !== e.w) begin
                    errors++;
                    $display("FAIL window_data at centre (%0d,%0d): got %h expected %h",
                             e.r, e.c, window_out, e.w);
                end
                checks++;
                if (int'(center_row) != e.r || int'(center_col) != e.c) begin
                    errors++;
                    $display("FAIL centre: got (%0d,%0d) expected (%0d,%0d)",
                             center_row, center_col, e.r, e.c);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL frame_done at centre (%0d,%0d): got %b expected %b",
                             e.r, e.c, frame_done, e.fd);
                end
            end
            nwin++;
            if (frame_done === 1'b1) nfd++;
            if (capture_first) begin
                first_w       = window_out;
                capture_first = 0;
            end
        end else begin
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL stray_frame_done: got %b expected 0", frame_done);
            end
            if (pixel_valid !== 1'b1) begin
                checks++;
                if (window_out !== prev_w || center_row !== prev_r || center_col !== prev_c) begin
                    errors++;
                    $display("FAIL hold_in_gap: row %0d col %0d expected row %0d col %0d, window changed=%b",
                             center_row, center_col, prev_r, prev_c, window_out !== prev_w);
                end
            end
        end
        prev_w = window_out;
        prev_r = center_row;
        prev_c = center_col;
    end

    int base_w;
    int base_f;

    initial begin
        rst         = 1'b1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_in    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Continuous pattern frame.
        base_w = nwin; base_f = nfd; capture_first = 1;
        send_frame(0, 0, 1, -1, -1);
        idle(3);
        chk(nwin - base_w == 100, "pattern_windows", nwin - base_w, 100);
        chk(nfd - base_f == 1, "pattern_frame_done", nfd - base_f, 1);
        chk(first_w[391 -: 8] == 8'd0, "first_A00", int'(first_w[391 -: 8]), 0);
        chk(first_w[199 -: 8] == 8'd51, "first_A33", int'(first_w[199 -: 8]), 51);
        chk(first_w[7:0] == 8'd102, "first_A66", int'(first_w[7:0]), 102);

        // Same frame with 50% gaps.
        base_w = nwin; base_f = nfd;
        send_frame(0, 50, 1, -1, -1);
        idle(3);
        chk(nwin - base_w == 100, "gap_windows", nwin - base_w, 100);
        chk(nfd - base_f == 1, "gap_frame_done", nfd - base_f, 1);

        // Two back-to-back frames, second inverted.
        base_w = nwin; base_f = nfd;
        send_frame(0, 0, 1, -1, -1);
        send_frame(1, 0, 1, -1, -1);
        idle(3);
        chk(nwin - base_w == 200, "b2b_windows", nwin - base_w, 200);
        chk(nfd - base_f == 2, "b2b_frame_done", nfd - base_f, 2);

        // Reset at pixel (9,4), then a frame without sof.
        base_w = nwin; base_f = nfd;
        send_frame(0, 0, 1, 9, 4);
        @(negedge clk);
        rst = 1'b1; pixel_valid = 1'b0; sof = 1'b0;
        mr = 0; mc = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(1, 0, 0, -1, -1);
        idle(3);
        chk(nwin - base_w == 130, "rst_windows", nwin - base_w, 130);
        chk(nfd - base_f == 1, "rst_frame_done", nfd - base_f, 1);

        // sof restart at pixel (8,10).
        base_w = nwin; base_f = nfd;
        send_frame(1, 0, 1, 8, 10);
        send_frame(0, 0, 1, -1, -1);
        idle(3);
        chk(nwin - base_w == 124, "sof_abort_windows", nwin - base_w, 124);
        chk(nfd - base_f == 1, "sof_abort_frame_done", nfd - base_f, 1);

        // Constant 200 frame with light gaps.
        base_w = nwin; base_f = nfd;
        send_frame(2, 20, 1, -1, -1);
        idle(3);
        chk(nwin - base_w == 100, "const_windows", nwin - base_w, 100);
        chk(nfd - base_f == 1, "const_frame_done", nfd - base_f, 1);

        // Random pixel frame with gaps.
        base_w = nwin; base_f = nfd;
        send_frame(3, 30, 1, -1, -1);
        idle(5);
        chk(nwin - base_w == 100, "random_windows", nwin - base_w, 100);
        chk(nfd - base_f == 1, "random_frame_done", nfd - base_f, 1);

        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
